// File: rtl/lfsr_stream_checker.sv
// ---------------------------------------------------------------------------
// lfsr_stream_checker
//
// Receive-side checker for the 18-bit XNOR pseudo-random generator that
// drives arrow/note selection. It samples the generator's serial output
// (generator register bit 0), loads 18 bits to synchronise, then predicts
// every following bit and flags/counts mismatches.
//
// Sampling rule: bit_in is taken on a rising clk edge only when bit_valid
// is 1. There is no back-pressure; the checker accepts every valid bit.
// Cycles with bit_valid = 0 leave all state untouched and keep bit_error 0.
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   reset         in   asynchronous, active-low; clears all state at once
//   bit_valid     in   bit_in is sampled on this edge
//   bit_in        in   serial stream bit (LSB of the generator register)
//   clear_counts  in   synchronous clear of error_count and bits_checked
//   locked        out  checker is synchronised and comparing
//   bit_error     out  one-cycle pulse, registered, per mismatched bit
//   error_count   out  saturating total of mismatches
//   bits_checked  out  saturating total of bits compared while locked
//   dbg_state     out  FSM state for observation: 0 = HUNT, 1 = LOCKED
// ---------------------------------------------------------------------------
module lfsr_stream_checker #(
    parameter int TAP       = 7,
    parameter int ERR_LIMIT = 4,
    parameter int WINDOW    = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_counts,
    output logic             locked,
    output logic             bit_error,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] bits_checked,
    output logic             dbg_state
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int ERR_W = $clog2(ERR_LIMIT + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [4:0]       LOAD_LAST = 5'd17;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Registered state and outputs
    state_e           state_q,     state_d;
    logic [17:0]      h_q,         h_d;
    logic [4:0]       load_q,      load_d;
    logic [WIN_W-1:0] win_cnt_q,   win_cnt_d;
    logic [ERR_W-1:0] win_err_q,   win_err_d;
    logic             locked_q,    locked_d;
    logic             bit_error_q, bit_error_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0] bits_q,      bits_d;

    // Helper terms
    logic             exp_bit;
    logic             mismatch;
    logic [17:0]      shift_in;
    logic [ERR_W-1:0] win_err_inc;

    // h[17] is the newest bit, h[0] the oldest. With the generator shifting
    // right and feeding r[0] ~^ r[TAP] into r[17], the stream obeys
    // s[n] = s[n-18] ~^ s[n-18+TAP], i.e. h[0] ~^ h[TAP].
    assign exp_bit     = h_q[0] ~^ h_q[TAP];
    assign mismatch    = (bit_in != exp_bit);
    assign shift_in    = {bit_in, h_q[17:1]};
    assign win_err_inc = win_err_q + ERR_W'(1);

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        load_d      = load_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        locked_d    = locked_q;
        bit_error_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bits_d      = bits_q;

        if (bit_valid) begin
            if (state_q == ST_HUNT) begin
                h_d = shift_in;
                if (load_q == LOAD_LAST) begin
                    load_d = '0;
                    // All ones is the XNOR lockup state; it never leaves
                    // itself, so reload instead of locking onto it.
                    if (shift_in != '1) begin
                        state_d   = ST_LOCKED;
                        locked_d  = 1'b1;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end else begin
                    load_d = load_q + 5'd1;
                end
            end else begin
                // Shift in the prediction, not the received bit, so one
                // corrupted sample cannot poison later predictions.
                h_d = {exp_bit, h_q[17:1]};

                if (bits_q != CNT_MAX) begin
                    bits_d = bits_q + CNT_W'(1);
                end

                if (mismatch) begin
                    bit_error_d = 1'b1;
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end

                // Loss of lock beats window rollover on the same bit.
                if (mismatch && (win_err_inc == ERR_MAX)) begin
                    state_d   = ST_HUNT;
                    locked_d  = 1'b0;
                    load_d    = '0;
                    win_err_d = '0;
                    win_cnt_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    if (mismatch) begin
                        win_err_d = win_err_inc;
                    end
                end
            end
        end

        // Clear wins over any increment on the same edge.
        if (clear_counts) begin
            err_cnt_d = '0;
            bits_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HUNT;
            h_q         <= '0;
            load_q      <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            bit_error_q <= 1'b0;
            err_cnt_q   <= '0;
            bits_q      <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            load_q      <= load_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            bit_error_q <= bit_error_d;
            err_cnt_q   <= err_cnt_d;
            bits_q      <= bits_d;
        end
    end

    assign locked       = locked_q;
    assign bit_error    = bit_error_q;
    assign error_count  = err_cnt_q;
    assign bits_checked = bits_q;
    assign dbg_state    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stream_checker
//
// Drives a generator stream (seed 0x00783) into lfsr_stream_checker with
// directed error patterns followed by a randomized phase. Every driven
// cycle pushes the expected post-edge outputs {locked, bit_error,
// error_count, bits_checked} into exp_q; a monitor pops and compares on the
// following falling edge.
// ---------------------------------------------------------------------------
module tb_lfsr_stream_checker;

    localparam int TAP       = 7;
    localparam int ERR_LIMIT = 4;
    localparam int WINDOW    = 64;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int EXP_W     = 2 + 2 * CNT_W;

    // ---------------- clock / reset ----------------
    logic clk          = 1'b0;
    logic reset        = 1'b1;
    logic bit_valid    = 1'b0;
    logic bit_in       = 1'b0;
    logic clear_counts = 1'b0;

    logic             locked;
    logic             bit_error;
    logic [CNT_W-1:0] error_count;
    logic [CNT_W-1:0] bits_checked;
    logic             dbg_state;

    always #5 clk = ~clk;

    lfsr_stream_checker #(
        .TAP       (TAP),
        .ERR_LIMIT (ERR_LIMIT),
        .WINDOW    (WINDOW),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .clear_counts (clear_counts),
        .locked       (locked),
        .bit_error    (bit_error),
        .error_count  (error_count),
        .bits_checked (bits_checked),
        .dbg_state    (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [EXP_W-1:0] act,
                         input logic [EXP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Generator: 18-bit register shifting right, XNOR feedback into bit 17.
    logic [17:0] gen_r = 18'h00783;

    // Checker model: last 18 accepted bits as a queue (index 0 = oldest).
    logic m_hist[$];
    bit   m_locked;
    int   m_load, m_win_cnt, m_win_err, m_err, m_bits;

    task automatic model_reset();
        m_hist.delete();
        m_locked  = 0;
        m_load    = 0;
        m_win_cnt = 0;
        m_win_err = 0;
        m_err     = 0;
        m_bits    = 0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic c,
                              output logic [EXP_W-1:0] e);
        logic be;
        logic p;
        int   ones;
        be = 1'b0;
        if (v) begin
            if (!m_locked) begin
                m_hist.push_back(b);
                if (m_hist.size() > 18) void'(m_hist.pop_front());
                m_load++;
                if (m_load == 18) begin
                    m_load = 0;
                    ones = 0;
                    foreach (m_hist[i]) if (m_hist[i]) ones++;
                    if (ones != 18) begin
                        m_locked  = 1;
                        m_win_cnt = 0;
                        m_win_err = 0;
                    end
                end
            end else begin
                p = m_hist[0] ~^ m_hist[TAP];
                void'(m_hist.pop_front());
                m_hist.push_back(p);
                if (m_bits < CNT_MAX) m_bits++;
                if (b != p) begin
                    be = 1'b1;
                    if (m_err < CNT_MAX) m_err++;
                    m_win_err++;
                end
                m_win_cnt++;
                if (be && m_win_err == ERR_LIMIT) begin
                    m_locked  = 0;
                    m_load    = 0;
                    m_win_err = 0;
                    m_win_cnt = 0;
                end else if (m_win_cnt == WINDOW) begin
                    m_win_cnt = 0;
                    m_win_err = 0;
                end
            end
        end
        if (c) begin
            m_err  = 0;
            m_bits = 0;
        end
        e = {m_locked, be, CNT_W'(m_err), CNT_W'(m_bits)};
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic b, input logic c);
        logic [EXP_W-1:0] e;
        @(negedge clk);
        bit_valid    = v;
        bit_in       = b;
        clear_counts = c;
        model_step(v, b, c, e);
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic send_gen(input logic inv, input logic clr);
        logic b;
        b     = gen_r[0];
        gen_r = {gen_r[0] ~^ gen_r[TAP], gen_r[17:1]};
        drive(1'b1, b ^ inv, clr);
    endtask

    task automatic pad_to_window();
        for (int k = 0; k < WINDOW && m_win_cnt != 0; k++) send_gen(1'b0, 1'b0);
    endtask

    task automatic async_reset(input bit check_now);
        @(negedge clk);
        #2;
        bit_valid    = 1'b0;
        clear_counts = 1'b0;
        reset        = 1'b0;
        #1;
        if (check_now) begin
            check("async_rst_locked", locked, 0);
            check("async_rst_bit_error", bit_error, 0);
            check("async_rst_error_count", error_count, 0);
            check("async_rst_bits_checked", bits_checked, 0);
        end
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (reset && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb", {locked, bit_error, error_count, bits_checked}, e);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timed out");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();

        // Power-on reset: assert between edges, check immediately.
        #1 reset = 1'b0;
        #1;
        check("rst_locked", locked, 0);
        check("rst_bit_error", bit_error, 0);
        check("rst_error_count", error_count, 0);
        check("rst_bits_checked", bits_checked, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Lock acquisition: locked only after the 18th sample's edge.
        repeat (17) send_gen(1'b0, 1'b0);
        #1 check("lock_after17", locked, 0);
        send_gen(1'b0, 1'b0);
        #1 check("lock_after18", locked, 1);
        repeat (200) send_gen(1'b0, 1'b0);
        #1;
        check("clean200_bits", bits_checked, 200);
        check("clean200_errs", error_count, 0);

        // Single error on the 30th checked bit from here.
        repeat (29) send_gen(1'b0, 1'b0);
        send_gen(1'b1, 1'b0);
        #1;
        check("single_pulse", bit_error, 1);
        check("single_count", error_count, 1);
        send_gen(1'b0, 1'b0);
        #1;
        check("single_pulse_end", bit_error, 0);
        check("single_locked", locked, 1);
        repeat (60) send_gen(1'b0, 1'b0);

        // Clear on an idle cycle, then 3 + 3 errors in two windows.
        drive(1'b0, 1'b0, 1'b1);
        #1;
        check("clear_errs", error_count, 0);
        check("clear_bits", bits_checked, 0);
        pad_to_window();
        for (int i = 0; i < 2 * WINDOW; i++) begin
            send_gen((i == 5 || i == 20 || i == 40 || i == 67 || i == 94 || i == 124), 1'b0);
        end
        #1;
        check("window_locked", locked, 1);
        check("window_errs", error_count, 6);

        // Loss of lock: 4 errors inside one window.
        pad_to_window();
        for (int i = 0; i < 30; i++) begin
            send_gen((i == 2 || i == 10 || i == 20 || i == 29), 1'b0);
        end
        #1;
        check("lol_locked", locked, 0);
        check("lol_pulse", bit_error, 1);
        check("lol_errs", error_count, 10);
        repeat (17) send_gen(1'b0, 1'b0);
        #1 check("relock_after17", locked, 0);
        send_gen(1'b0, 1'b0);
        #1 check("relock_after18", locked, 1);
        repeat (80) send_gen(1'b0, 1'b0);
        #1 check("relock_clean_errs", error_count, 10);

        // Gaps: alternating valid, idle cycles carry garbage on bit_in.
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) send_gen(1'b0, 1'b0);
            else            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        #1;
        check("gap_bits", bits_checked, 50);
        check("gap_errs", error_count, 0);

        // clear_counts together with an error.
        send_gen(1'b1, 1'b1);
        #1;
        check("clr_err_pulse", bit_error, 1);
        check("clr_err_count", error_count, 0);
        check("clr_err_bits", bits_checked, 0);

        // Randomized phase.
        for (int i = 0; i < 1500; i++) begin
            logic v, inv, c;
            v   = ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 49) == 0);
            c   = ($urandom_range(0, 99) == 0);
            if (v) send_gen(inv, c);
            else   drive(1'b0, 1'($urandom_range(0, 1)), c);
        end

        // Mid-lock asynchronous reset while bit_error is high.
        repeat (300) send_gen(1'b0, 1'b0);
        send_gen(1'b1, 1'b0);
        #1;
        check("pre_rst_locked", locked, 1);
        check("pre_rst_pulse", bit_error, 1);
        async_reset(1'b1);

        // All-ones lockup: stays in HUNT and reloads.
        repeat (18) drive(1'b1, 1'b1, 1'b0);
        #1 check("ones18_locked", locked, 0);
        repeat (18) drive(1'b1, 1'b1, 1'b0);
        #1 check("ones36_locked", locked, 0);
        repeat (18) send_gen(1'b0, 1'b0);
        #1 check("after_ones_lock", locked, 1);
        repeat (50) send_gen(1'b0, 1'b0);
        #1;
        check("final_errs", error_count, 0);
        check("final_bits", bits_checked, 50);

        // Drain the scoreboard.
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 check("drain", EXP_W'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive-side companion to the 18-bit XNOR pseudo-random generator that drives arrow/note selection.
- Samples the generator's serial output bit (generator register bit 0, one bit per valid cycle).
- Self-synchronises to the sequence, predicts each following bit, and flags and counts mismatches.
- Used in-system to validate the random stream crossing into the note scheduler, and as a standalone self-check.

Parameters:
- TAP, 7, feedback tap index: expected = h[0] XNOR h[TAP].
- ERR_LIMIT, 4, errors within one window that force loss of lock.
- WINDOW, 64, valid bits per error-rate window; must be ≥ 2.
- CNT_W, 16, width of the saturating counters.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- bit_valid  input  1  bit_in is sampled on this posedge.
- bit_in  input  1  serial stream bit, LSB of the generator register.
- clear_counts  input  1  synchronous clear of error_count and bits_checked.
- locked  output  1  checker is synchronised and comparing.
- bit_error  output  1  one-cycle pulse for each mismatched bit.
- error_count  output  CNT_W  saturating total of mismatches.
- bits_checked  output  CNT_W  saturating total of bits compared while locked.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = HUNT.
  - h[17:0] = 0, load_cnt = 0, win_cnt = 0, win_err = 0.
  - locked = 0, bit_error = 0, error_count = 0, bits_checked = 0.
- Reset deassertion is synchronised externally. The first active edge after deassertion behaves as a normal cycle.
- History register h[17:0]: h[17] is the newest bit and h[0] the oldest. Every shift is h <= {new, h[17:1]}.
- Cycles with bit_valid = 0 change no state and keep bit_error = 0.
- HUNT state:
  - Each valid bit: h <= {bit_in, h[17:1]}; load_cnt++.
  - On the 18th valid bit (load_cnt == 17):
    - If the resulting h is all ones (the XNOR lockup pattern): load_cnt <= 0 and stay in HUNT.
    - Otherwise: state <= LOCKED, load_cnt <= 0, win_cnt <= 0, win_err <= 0.
  - locked rises on the edge that performs this transition, so it is visible the cycle after the 18th bit is sampled.
- LOCKED state, each valid bit:
  - exp = h[0] ~^ h[TAP].
  - h <= {exp, h[17:1]}. The predicted bit is shifted in, so a single bad bit never corrupts later predictions.
  - bits_checked++ (saturates at all ones).
  - If bit_in != exp:
    - bit_error = 1 for exactly the next cycle (registered, latency 1).
    - error_count++ (saturating).
    - win_err++.
  - win_cnt++. When win_cnt reaches WINDOW-1 on a valid bit: win_cnt <= 0 and win_err <= 0.
  - If a mismatch makes win_err reach ERR_LIMIT: state <= HUNT, locked <= 0 (same edge as the bit_error registration), load_cnt <= 0, win_err <= 0.
- Simultaneous events:
  - Window rollover and the ERR_LIMIT-th error on the same bit: loss of lock takes priority.
  - clear_counts together with a counted event: clear wins, counters become 0 and the event is dropped. bit_error still pulses.
  - clear_counts does not affect state, h, window counters or locked.
- Saturation: error_count and bits_checked hold at 2^CNT_W-1 and never wrap.
- Reset mid-lock: immediate return to HUNT with all outputs 0. A fresh 18-bit load is required.

Test Plan:
- Lock acquisition:
  - Stimulus: reset low 2 cycles, then drive the generator stream seeded with START_NUM 0x00783, bit_valid = 1 continuously.
  - Response: locked = 0 through the 18th sample, locked = 1 the following cycle.
  - Then run 200 bits: error_count = 0, bits_checked = 200, bit_error never pulses.
- Single error:
  - Stimulus: when locked, invert the 30th checked bit.
  - Response: bit_error pulses exactly 1 cycle, one cycle after that sample; error_count = 1; locked stays 1.
  - All following bits compare clean.
- Loss of lock:
  - Stimulus: invert 4 bits within one 64-bit window.
  - Response: locked falls on the edge that registers the 4th bit_error; error_count = 4.
  - A re-lock occurs 18 valid bits later, with no further errors.
- Window rollover:
  - Stimulus: 3 errors in window 1, then 3 errors in window 2.
  - Response: locked stays 1 throughout; error_count = 6.
- Lockup and gaps:
  - All-ones stimulus: 18 ones in HUNT means locked stays 0 and loading restarts.
  - Gap stimulus: bit_valid toggled 1/0 during lock.
  - Gap response: idle cycles change nothing; bits_checked counts valid samples only.
- Reset and clear:
  - Mid-lock asynchronous reset: locked, bit_error and counters go to 0 immediately, without waiting for a clock edge.
  - clear_counts pulse coinciding with an error: bit_error pulses but error_count reads 0 afterwards.
